tpfu_burst_feeder: RTL and testbench
====================================

// Module: tpfu_burst_feeder
// PURPOSE
//  Transmit side of the TP-FU input stream. Pulls 16-bit words from an upstream FWFT FIFO and
//  stages BURST_LEN of them, then drives them to the FU as one unbroken fu_valid burst.
//  Captures the FU's fu_dout/fu_dout_v result pulses and writes them to a downstream FIFO.
//  Sits between the host read FIFO / write FIFO pair and one TP-FU instance.
// PARAMETERS
//  DATA_W     16  word width of all data paths
//  BURST_LEN  4   words per burst, 1..64 (FU register-file depth)
//  RESULTS    2   fu_dout_v pulses expected per burst, 1..16
//  TIMEOUT    64  max cycles in WAIT before abandoning the burst, >=8
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-low reset (0 = reset)
//  in_data    in   DATA_W  upstream FIFO head word, valid while in_empty=0
//  in_empty   in   1       upstream FIFO empty
//  in_rd_en   out  1       pop upstream head this cycle
//  fu_din     out  DATA_W  word to FU
//  fu_valid   out  1       FU input valid; high for exactly BURST_LEN consecutive cycles
//  fu_dout    in   DATA_W  FU result word
//  fu_dout_v  in   1       FU result strobe, single-cycle, no backpressure
//  out_data   out  DATA_W  downstream FIFO write data
//  out_wr_en  out  1       downstream FIFO write strobe
//  out_full   in   1       downstream FIFO full
//  busy       out  1       state != IDLE
//  timeout_err out 1       sticky: a burst timed out waiting for results
//  burst_cnt  out  16      completed bursts, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; all outputs 0; counters, timeout_err cleared.
//    Reset mid-operation aborts at once; words already popped are discarded.
//  - fu_valid, fu_din, out_wr_en, out_data registered; in_rd_en combinational = FILL & ~in_empty.
//  - FSM IDLE->FILL->SEND->WAIT->DRAIN->IDLE:
//   IDLE : ~in_empty -> FILL (no pop in IDLE).
//   FILL : pop when ~in_empty, in_data into stage[fill_cnt]; gaps tolerated.
//          Last word popped (fill_cnt=BURST_LEN-1) -> SEND.
//   SEND : fu_valid=1, fu_din=stage[i], i=0..BURST_LEN-1 on consecutive cycles, rising
//          on the cycle after the last pop; no gaps. Then fu_valid=0, fu_din=0 -> WAIT.
//   WAIT : each fu_dout_v stores fu_dout into res[res_cnt]; res_cnt==RESULTS -> DRAIN.
//          Pulses beyond RESULTS ignored. Wait counter reaching TIMEOUT first ->
//          timeout_err<=1, DRAIN with res_cnt captured words (0 allowed).
//   DRAIN: res[j] to out_data with out_wr_en=1 only when out_full=0; j++ per write.
//          out_full pauses without loss or reorder. j==res_cnt -> IDLE, burst_cnt++.
//  - fu_dout_v outside WAIT is ignored.
//  - fu_valid is low from end of SEND until next SEND, so the FU always sees a falling edge
//    and at least RESULTS+1 idle cycles between bursts.
//  - Latency (empty->first fu_valid) = BURST_LEN pop cycles + 1 when upstream stays non-empty.
// TESTING
//  1 FIFO preloaded 0x0003,0x0005,0x0007,0x0009, BURST_LEN=4 -> fu_valid high exactly 4
//    cycles, fu_din 3,5,7,9; FU model returns 0x0003,0x0064 -> out gets 0x0003,0x0064, burst_cnt=1.
//  2 Upstream words arrive one per 3 cycles -> in_rd_en only when non-empty; fu_valid still
//    4 contiguous cycles with correct order.
//  3 out_full held 1 for 5 cycles mid-DRAIN -> no out_wr_en while full; both results written
//    once, in order.
//  4 FU model returns one pulse only, TIMEOUT=64 -> 64 cycles after WAIT entry timeout_err=1,
//    one word written, IDLE; next burst completes normally, timeout_err stays 1.
//  5 rst=0 on 2nd SEND cycle -> next cycle fu_valid=0, busy=0, burst_cnt=0, timeout_err=0.
//  6 12 words queued, 3 bursts back-to-back -> 6 results in order, fu_valid low between
//    bursts, burst_cnt=3; extra fu_dout_v pulse injected in IDLE produces no write.

Source files
------------

// File: rtl/tpfu_burst_feeder_if.sv
// tpfu_burst_feeder_if: upstream FIFO, FU stream and downstream FIFO
// signals of one burst feeder, grouped by the side that drives them.
interface tpfu_burst_feeder_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_empty;
  logic              in_rd_en;
  logic [DATA_W-1:0] fu_din;
  logic              fu_valid;
  logic [DATA_W-1:0] fu_dout;
  logic              fu_dout_v;
  logic [DATA_W-1:0] out_data;
  logic              out_wr_en;
  logic              out_full;

  modport master (
    input  in_data, in_empty,
    input  fu_dout, fu_dout_v,
    input  out_full,
    output in_rd_en,
    output fu_din, fu_valid,
    output out_data, out_wr_en
  );

  modport slave (
    output in_data, in_empty,
    output fu_dout, fu_dout_v,
    output out_full,
    input  in_rd_en,
    input  fu_din, fu_valid,
    input  out_data, out_wr_en
  );
endinterface

// File: rtl/tpfu_burst_feeder.sv
// tpfu_burst_feeder: stages BURST_LEN words from an upstream FIFO,
// bursts them into a TP-FU and forwards the FU results downstream.
module tpfu_burst_feeder #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int RESULTS   = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  tpfu_burst_feeder_if.master    bus,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            burst_cnt
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int RC = $clog2(RESULTS + 1);
  localparam int RI = (RESULTS > 1) ? $clog2(RESULTS) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] BL_N     = CW'(BURST_LEN);
  localparam logic [CW-1:0] BL_LAST  = CW'(BURST_LEN - 1);
  localparam logic [RC-1:0] RES_LAST = RC'(RESULTS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, SEND, WAIT, DRAIN
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] stage [1<<IW];
  logic [DATA_W-1:0] res   [1<<RI];
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     send_cnt;
  logic [RC-1:0]     res_cnt;
  logic [RC-1:0]     drain_cnt;
  logic [TW-1:0]     wait_cnt;

  assign bus.in_rd_en = (state == FILL) && !bus.in_empty;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      send_cnt      <= '0;
      res_cnt       <= '0;
      drain_cnt     <= '0;
      wait_cnt      <= '0;
      bus.fu_valid  <= 1'b0;
      bus.fu_din    <= '0;
      bus.out_wr_en <= 1'b0;
      bus.out_data  <= '0;
      timeout_err   <= 1'b0;
      burst_cnt     <= '0;
    end else begin
      bus.out_wr_en <= 1'b0;
      bus.out_data  <= '0;
      unique case (state)
        IDLE: begin
          fill_cnt <= '0;
          if (!bus.in_empty) state <= FILL;
        end
        FILL: begin
          if (!bus.in_empty) begin
            stage[fill_cnt[IW-1:0]] <= bus.in_data;
            if (fill_cnt == BL_LAST) begin
              // first word goes out on the cycle after the last pop
              state        <= SEND;
              bus.fu_valid <= 1'b1;
              bus.fu_din   <= (fill_cnt == '0) ? bus.in_data : stage[0];
              send_cnt     <= CW'(1);
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        SEND: begin
          if (send_cnt == BL_N) begin
            bus.fu_valid <= 1'b0;
            bus.fu_din   <= '0;
            state        <= WAIT;
            wait_cnt     <= '0;
            res_cnt      <= '0;
          end else begin
            bus.fu_din <= stage[send_cnt[IW-1:0]];
            send_cnt   <= send_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus.fu_dout_v) begin
            res[res_cnt[RI-1:0]] <= bus.fu_dout;
            res_cnt              <= res_cnt + 1'b1;
          end
          if (bus.fu_dout_v && res_cnt == RES_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= DRAIN;
            drain_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == res_cnt) begin
            state     <= IDLE;
            burst_cnt <= burst_cnt + 16'd1;
          end else if (!bus.out_full) begin
            bus.out_wr_en <= 1'b1;
            bus.out_data  <= res[drain_cnt[RI-1:0]];
            drain_cnt     <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpfu_burst_feeder.sv
// tb_tpfu_burst_feeder: FIFO and FU models around the burst feeder,
// scoreboarded against words pushed and results the FU model emitted.
module tb_tpfu_burst_feeder;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam int NR = 2;
  localparam int TO = 64;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tpfu_burst_feeder_if #(.DATA_W(DW)) bus();
  logic        busy;
  logic        timeout_err;
  logic [15:0] burst_cnt;

  tpfu_burst_feeder #(
    .DATA_W(DW), .BURST_LEN(BL), .RESULTS(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .timeout_err(timeout_err), .burst_cnt(burst_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  wq_t up_q, sent, fu_log, out_log, exp_out, fixed_res;
  int run_log[$];
  int rd_viol = 0, full_viol = 0;
  int fu_npulses = NR, fu_delay_max = 0;
  int wait_start = 0, to_cyc = -1, first_fv = -1;
  bit inj_pulse = 0, full_req = 0, full_rand = 0;
  logic full_at_edge = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) full_at_edge <= bus.out_full;

  // upstream FWFT FIFO
  initial begin
    bit pend;
    pend = 0;
    bus.in_empty = 1'b1;
    bus.in_data = '0;
    forever begin
      @(negedge clk);
      if (pend && up_q.size() > 0) void'(up_q.pop_front());
      bus.in_empty = (up_q.size() == 0);
      bus.in_data = (up_q.size() > 0) ? up_q[0] : '0;
      #1;
      pend = bus.in_rd_en;
      if (bus.in_rd_en && bus.in_empty) rd_viol++;
    end
  end

  // FU model: collects a burst, later emits fu_npulses result strobes
  initial begin
    int run, left, k, at;
    logic [15:0] v;
    run = 0; left = 0; k = 0; at = 0;
    bus.fu_dout_v = 1'b0;
    bus.fu_dout = '0;
    forever begin
      @(negedge clk);
      bus.fu_dout_v = 1'b0;
      bus.fu_dout = '0;
      if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = cyc;
      if (bus.fu_valid === 1'b1) begin
        if (run == 0 && first_fv < 0) first_fv = cyc;
        fu_log.push_back(bus.fu_din);
        run++;
      end else if (run > 0) begin
        run_log.push_back(run);
        run = 0;
        wait_start = cyc;
        left = fu_npulses;
        k = 0;
        at = cyc + $urandom_range(fu_delay_max, 0);
      end
      if (inj_pulse) begin
        bus.fu_dout_v = 1'b1;
        bus.fu_dout = 16'hBEEF;
        inj_pulse = 0;
      end else if (left > 0 && cyc >= at) begin
        v = (fixed_res.size() > 0) ? fixed_res.pop_front() : 16'($urandom);
        bus.fu_dout_v = 1'b1;
        bus.fu_dout = v;
        if (k < NR) exp_out.push_back(v);
        k++;
        left--;
        at = cyc + 2;
      end
    end
  end

  // downstream FIFO
  initial forever begin
    @(negedge clk);
    if (bus.out_wr_en === 1'b1) begin
      out_log.push_back(bus.out_data);
      if (full_at_edge) full_viol++;
    end
  end

  initial begin
    bus.out_full = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      bus.out_full = full_rand ? ($urandom_range(2, 0) == 0) : full_req;
    end
  end

  function automatic int qdiff(input wq_t a, input wq_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic int bad_runs();
    int n;
    n = 0;
    foreach (run_log[i]) if (run_log[i] != BL) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    fu_log.delete(); out_log.delete(); exp_out.delete();
    run_log.delete(); fixed_res.delete(); sent.delete();
    rd_viol = 0; full_viol = 0; first_fv = -1;
  endtask

  task automatic push(input int n, input int gmax);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom);
      up_q.push_back(v);
      sent.push_back(v);
      if (gmax > 0) tick($urandom_range(gmax, gmax > 2 ? gmax : 0));
    end
  endtask

  task automatic wait_done(input int nout, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      #3;
      if (out_log.size() >= nout && !busy && up_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    #1;
    total++;
    if ({bus.fu_valid, bus.out_wr_en, busy, timeout_err, bus.in_rd_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
        {bus.fu_valid, bus.out_wr_en, busy, timeout_err, bus.in_rd_en});
    end
    total++;
    if (bus.fu_din !== 16'h0) begin
      bad++; $display("FAIL reset_fu_din got=%h exp=0000", bus.fu_din);
    end
    total++;
    if (bus.out_data !== 16'h0) begin
      bad++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data);
    end
    total++;
    if (burst_cnt !== 16'h0) begin
      bad++; $display("FAIL reset_burst_cnt got=%0d exp=0", burst_cnt);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    wq_t ev;
    bit ok;
    int c0, d;
    clr();
    fu_npulses = NR; fu_delay_max = 0;
    fixed_res.push_back(16'h0003);
    fixed_res.push_back(16'h0064);
    ev = '{16'h0003, 16'h0005, 16'h0007, 16'h0009};
    foreach (ev[i]) begin up_q.push_back(ev[i]); sent.push_back(ev[i]); end
    c0 = cyc;
    wait_done(2, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done got=timeout exp=done"); end
    total++;
    if (first_fv - c0 != BL + 1) begin
      bad++; $display("FAIL basic_latency got=%0d exp=%0d", first_fv - c0, BL + 1);
    end
    d = qdiff(fu_log, sent);
    total++;
    if (d != -1) begin
      bad++; $display("FAIL basic_fu_din diff_at=%0d got_n=%0d exp_n=%0d", d, fu_log.size(), sent.size());
    end
    total++;
    if (run_log.size() != 1 || bad_runs() != 0) begin
      bad++; $display("FAIL basic_run runs=%0d bad_len=%0d exp=1,0", run_log.size(), bad_runs());
    end
    ev = '{16'h0003, 16'h0064};
    d = qdiff(out_log, ev);
    total++;
    if (d != -1) begin
      bad++; $display("FAIL basic_out diff_at=%0d got_n=%0d exp_n=2", d, out_log.size());
    end
    total++;
    if (burst_cnt !== 16'd1 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL basic_cnt got=%0d/%b exp=1/0", burst_cnt, timeout_err);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    int d;
    clr();
    fu_delay_max = 5;
    push(BL, 3);
    wait_done(NR, 300, ok);
    total++;
    if (!ok || rd_viol != 0) begin
      bad++; $display("FAIL gaps_rd ok=%0d rd_when_empty=%0d exp=1,0", ok, rd_viol);
    end
    d = qdiff(fu_log, sent);
    total++;
    if (d != -1 || run_log.size() != 1 || bad_runs() != 0) begin
      bad++; $display("FAIL gaps_fu diff_at=%0d runs=%0d exp=-1,1", d, run_log.size());
    end
    d = qdiff(out_log, exp_out);
    total++;
    if (d != -1 || burst_cnt !== 16'd2) begin
      bad++; $display("FAIL gaps_out diff_at=%0d cnt=%0d exp=-1,2", d, burst_cnt);
    end
  endtask

  task automatic test_full();
    bit ok, seen;
    int d;
    clr();
    fu_delay_max = 0;
    push(BL, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (out_log.size() >= 1) seen = 1;
    end
    full_req = 1;
    repeat (5) @(negedge clk);
    #1;
    full_req = 0;
    wait_done(NR, 200, ok);
    total++;
    if (!seen || !ok) begin
      bad++; $display("FAIL full_done seen=%0d ok=%0d exp=1,1", seen, ok);
    end
    total++;
    if (full_viol != 0) begin
      bad++; $display("FAIL full_write_while_full got=%0d exp=0", full_viol);
    end
    d = qdiff(out_log, exp_out);
    total++;
    if (d != -1) begin
      bad++; $display("FAIL full_out diff_at=%0d got_n=%0d exp_n=%0d", d, out_log.size(), exp_out.size());
    end
    total++;
    if (burst_cnt !== 16'd3) begin
      bad++; $display("FAIL full_cnt got=%0d exp=3", burst_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int d;
    clr();
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_pre got=%b exp=0", timeout_err);
    end
    fu_npulses = 1; fu_delay_max = 3; to_cyc = -1;
    push(BL, 0);
    wait_done(1, 300, ok);
    total++;
    if (!ok || timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_flag ok=%0d got=%b exp=1", ok, timeout_err);
    end
    total++;
    if (to_cyc - wait_start != TO) begin
      bad++; $display("FAIL to_delay got=%0d exp=%0d", to_cyc - wait_start, TO);
    end
    d = qdiff(out_log, exp_out);
    total++;
    if (d != -1 || out_log.size() != 1 || burst_cnt !== 16'd4) begin
      bad++; $display("FAIL to_out diff_at=%0d n=%0d cnt=%0d exp=-1,1,4", d, out_log.size(), burst_cnt);
    end
    clr();
    fu_npulses = NR;
    push(BL, 0);
    wait_done(NR, 300, ok);
    d = qdiff(out_log, exp_out);
    total++;
    if (!ok || d != -1 || burst_cnt !== 16'd5 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_next ok=%0d diff_at=%0d cnt=%0d err=%b exp=1,-1,5,1", ok, d, burst_cnt, timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clr();
    fu_npulses = 0;
    push(BL, 0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.fu_valid === 1'b1) seen = 1;
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (!seen || {bus.fu_valid, busy, timeout_err} !== 3'b0 || burst_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_mid seen=%0d got=%b cnt=%0d exp=1,000,0", seen, {bus.fu_valid, busy, timeout_err}, burst_cnt);
    end
    rst = 1'b1;
    tick(10);
    total++;
    if (busy !== 1'b0 || out_log.size() != 0) begin
      bad++; $display("FAIL rst_after busy=%b writes=%0d exp=0,0", busy, out_log.size());
    end
    fu_npulses = NR;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    clr();
    fu_npulses = NR + 1; fu_delay_max = 4;
    push(3 * BL, 0);
    wait_done(3 * NR, 600, ok);
    d = qdiff(fu_log, sent);
    total++;
    if (!ok || d != -1) begin
      bad++; $display("FAIL b2b_fu ok=%0d diff_at=%0d exp=1,-1", ok, d);
    end
    total++;
    if (run_log.size() != 3 || bad_runs() != 0) begin
      bad++; $display("FAIL b2b_runs got=%0d bad_len=%0d exp=3,0", run_log.size(), bad_runs());
    end
    d = qdiff(out_log, exp_out);
    total++;
    if (d != -1 || burst_cnt !== 16'd3) begin
      bad++; $display("FAIL b2b_out diff_at=%0d cnt=%0d exp=-1,3", d, burst_cnt);
    end
    tick(10);
    inj_pulse = 1;
    tick(10);
    total++;
    if (out_log.size() != 3 * NR || busy !== 1'b0) begin
      bad++; $display("FAIL idle_pulse writes=%0d busy=%b exp=%0d,0", out_log.size(), busy, 3 * NR);
    end
    fu_npulses = NR;
  endtask

  task automatic test_random();
    bit ok;
    int d;
    clr();
    full_rand = 1; fu_delay_max = 10; fu_npulses = NR;
    push(10 * BL, 2);
    wait_done(10 * NR, 3000, ok);
    full_rand = 0;
    d = qdiff(fu_log, sent);
    total++;
    if (!ok || d != -1 || bad_runs() != 0 || run_log.size() != 10) begin
      bad++; $display("FAIL rnd_fu ok=%0d diff_at=%0d runs=%0d exp=1,-1,10", ok, d, run_log.size());
    end
    d = qdiff(out_log, exp_out);
    total++;
    if (d != -1 || full_viol != 0 || rd_viol != 0) begin
      bad++; $display("FAIL rnd_out diff_at=%0d full_viol=%0d rd_viol=%0d exp=-1,0,0", d, full_viol, rd_viol);
    end
    total++;
    if (burst_cnt !== 16'd13) begin
      bad++; $display("FAIL rnd_cnt got=%0d exp=13", burst_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
